// File: rtl/source_switch_pkg.sv
// Shared types and defaults for the source switch sequencer.
// The feature macro SOURCE_SWITCH_FRONTEND_RESET_EN is consumed in source_switch_sequencer.sv.
package source_switch_pkg;

   localparam int CNT_W = 16;

   localparam int MUTE_CYCLES_DEF   = 4096;
   localparam int RESET_CYCLES_DEF  = 8192;
   localparam int SETTLE_CYCLES_DEF = 16384;
   localparam int LRCK_TIMEOUT_DEF  = 65535;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_MUTE   = 3'd1,
      ST_FRST   = 3'd2,
      ST_SWITCH = 3'd3,
      ST_SETTLE = 3'd4,
      ST_UNMUTE = 3'd5
   } sw_state_t;

endpackage

// File: rtl/lrck_edge_sync.sv
// Brings the foreign-domain lrck into clk through two flops and flags its rising edge.
module lrck_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic lrck,
   output logic rise
);

   logic meta_r;
   logic sync_r;
   logic prev_r;

   // synchroniser chain plus one delay flop for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
         prev_r <= 1'b0;
      end else begin
         meta_r <= lrck;
         sync_r <= meta_r;
         prev_r <= sync_r;
      end
   end

   assign rise = sync_r & ~prev_r;

endmodule

// File: rtl/source_switch_sequencer.sv
// Mute / front-end reset / switch / settle / unmute sequencer for audio source changes.
// Define SOURCE_SWITCH_FRONTEND_RESET_EN to drive frontend_rst_n low during FRST and SWITCH.
module source_switch_sequencer
   import source_switch_pkg::*;
#(
   parameter int MUTE_CYCLES   = MUTE_CYCLES_DEF,
   parameter int RESET_CYCLES  = RESET_CYCLES_DEF,
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter int LRCK_TIMEOUT  = LRCK_TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic sel_in,
   input  logic sel_changed,
   input  logic lrck,
   output logic mute,
   output logic frontend_rst_n,
   output logic active_sel,
   output logic busy
);

`ifdef SOURCE_SWITCH_FRONTEND_RESET_EN
   localparam logic FE_RESET_EN = 1'b1;
`else
   localparam logic FE_RESET_EN = 1'b0;
`endif

   // without the front-end reset FRST collapses to a single cycle
   localparam cnt_t MUTE_LAST   = cnt_t'(MUTE_CYCLES - 32'sd1);
   localparam cnt_t FRST_LAST   = FE_RESET_EN ? cnt_t'(RESET_CYCLES - 32'sd1) : cnt_t'(32'sd0);
   localparam cnt_t SETTLE_LAST = cnt_t'(SETTLE_CYCLES - 32'sd1);
   localparam cnt_t TO_LAST     = cnt_t'(LRCK_TIMEOUT - 32'sd1);

   sw_state_t state_r;
   sw_state_t state_s;
   cnt_t      cnt_r;
   cnt_t      cnt_s;
   logic      sel_changed_d_r;
   logic      sel_event_s;
   logic      lrck_rise_s;
   logic      mute_s;
   logic      frontend_rst_n_s;
   logic      active_sel_s;
   logic      busy_s;

   lrck_edge_sync u_lrck_sync (
      .clk   (clk),
      .reset (reset),
      .lrck  (lrck),
      .rise  (lrck_rise_s)
   );

   // next state, shared counter and next output values
   always_comb begin
      state_s     = state_r;
      sel_event_s = (sel_changed & ~sel_changed_d_r) | (sel_in != active_sel);

      case (state_r)
         ST_IDLE: begin
            if (sel_event_s) begin
               state_s = ST_MUTE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_MUTE: begin
            if (cnt_r == MUTE_LAST) begin
               state_s = ST_FRST;
            end else begin
               state_s = ST_MUTE;
            end
         end
         ST_FRST: begin
            if (cnt_r == FRST_LAST) begin
               state_s = ST_SWITCH;
            end else begin
               state_s = ST_FRST;
            end
         end
         ST_SWITCH: begin
            state_s = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (sel_event_s) begin
               state_s = ST_FRST;
            end else if (cnt_r == SETTLE_LAST) begin
               state_s = ST_UNMUTE;
            end else begin
               state_s = ST_SETTLE;
            end
         end
         ST_UNMUTE: begin
            // a new selection outranks a simultaneous lrck edge
            if (sel_event_s) begin
               state_s = ST_FRST;
            end else if (lrck_rise_s || (cnt_r == TO_LAST)) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_UNMUTE;
            end
         end
         default: begin
            state_s = ST_FRST;
         end
      endcase

      if ((state_s != state_r) || (state_s == ST_IDLE)) begin
         cnt_s = {CNT_W{1'b0}};
      end else begin
         cnt_s = cnt_r + cnt_t'(32'sd1);
      end

      mute_s           = (state_s != ST_IDLE);
      busy_s           = (state_s != ST_IDLE);
      frontend_rst_n_s = ~(FE_RESET_EN & ((state_s == ST_FRST) | (state_s == ST_SWITCH)));

      if (state_r == ST_SWITCH) begin
         active_sel_s = sel_in;
      end else begin
         active_sel_s = active_sel;
      end
   end

   // state, counter and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r         <= ST_FRST;
         cnt_r           <= {CNT_W{1'b0}};
         sel_changed_d_r <= 1'b0;
         mute            <= 1'b1;
         frontend_rst_n  <= ~FE_RESET_EN;
         active_sel      <= 1'b0;
         busy            <= 1'b1;
      end else begin
         state_r         <= state_s;
         cnt_r           <= cnt_s;
         sel_changed_d_r <= sel_changed;
         mute            <= mute_s;
         frontend_rst_n  <= frontend_rst_n_s;
         active_sel      <= active_sel_s;
         busy            <= busy_s;
      end
   end

endmodule

// File: tb/tb_source_switch_sequencer.sv
// Directed bench for source_switch_sequencer with shortened timing parameters.
// Expectations follow SOURCE_SWITCH_FRONTEND_RESET_EN as seen by this file.
module tb_source_switch_sequencer;

`ifdef SOURCE_SWITCH_FRONTEND_RESET_EN
   localparam bit FE_EN = 1'b1;
`else
   localparam bit FE_EN = 1'b0;
`endif

   localparam int FRST_LEN  = FE_EN ? 8 : 1;
   localparam int LOW_LEN   = FE_EN ? 9 : 0;
   localparam int EXP_FIRST = FE_EN ? 5 : -1;

   logic clk = 1'b0;
   logic reset;
   logic sel_in;
   logic sel_changed;
   logic lrck;
   logic mute;
   logic frontend_rst_n;
   logic active_sel;
   logic busy;

   int errors = 0;
   int checks = 0;
   logic exp_frst_rst;

   always #5 clk = ~clk;

   source_switch_sequencer #(
      .MUTE_CYCLES   (4),
      .RESET_CYCLES  (8),
      .SETTLE_CYCLES (16),
      .LRCK_TIMEOUT  (64)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .sel_in         (sel_in),
      .sel_changed    (sel_changed),
      .lrck           (lrck),
      .mute           (mute),
      .frontend_rst_n (frontend_rst_n),
      .active_sel     (active_sel),
      .busy           (busy)
   );

   task automatic check_reset_values(input string tag);
      checks += 4;
      if (mute !== 1'b1) begin errors++; $display("FAIL %s mute: got %b expected 1", tag, mute); end
      if (frontend_rst_n !== exp_frst_rst) begin errors++; $display("FAIL %s frontend_rst_n: got %b expected %b", tag, frontend_rst_n, exp_frst_rst); end
      if (active_sel !== 1'b0) begin errors++; $display("FAIL %s active_sel: got %b expected 0", tag, active_sel); end
      if (busy !== 1'b1) begin errors++; $display("FAIL %s busy: got %b expected 1", tag, busy); end
   endtask

   task automatic test_reset();
      reset = 1'b0; sel_in = 1'b1; sel_changed = 1'b0; lrck = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
   endtask

   // power-up, lrck edges in SETTLE ignored, unmute on the first lrck edge in UNMUTE
   task automatic test_powerup();
      int e;
      int low_cnt;
      int early;
      e = FRST_LEN + 17;
      low_cnt = 0; early = 0;
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k <= e + 5; k++) begin
         if (k > 0) @(negedge clk);
         if (frontend_rst_n === 1'b0) low_cnt++;
         if ((k < e + 5) && (mute !== 1'b1)) early++;
         if (k == e + 4) begin
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL powerup busy_before: got %b expected 1", busy); end
         end
         if (k == e + 5) begin
            checks += 2;
            if (mute !== 1'b0) begin errors++; $display("FAIL powerup mute_edge: got %b expected 0", mute); end
            if (busy !== 1'b0) begin errors++; $display("FAIL powerup busy_idle: got %b expected 0", busy); end
         end
         if (k == 5) lrck = 1'b1;
         if (k == 8) lrck = 1'b0;
         if (k == e + 2) lrck = 1'b1;
      end
      checks += 4;
      if (low_cnt != LOW_LEN) begin errors++; $display("FAIL powerup rst_low_cycles: got %0d expected %0d", low_cnt, LOW_LEN); end
      if (early != 0) begin errors++; $display("FAIL powerup early_unmute: got %0d expected 0", early); end
      if (active_sel !== 1'b1) begin errors++; $display("FAIL powerup active_sel: got %b expected 1", active_sel); end
      if (frontend_rst_n !== 1'b1) begin errors++; $display("FAIL powerup frst_final: got %b expected 1", frontend_rst_n); end
   endtask

   // held sel_changed triggers one sequence; lrck silent so unmute is by timeout
   task automatic test_sel_change();
      int e2;
      int low_cnt;
      int first_low;
      int rises;
      logic prev_mute;
      e2 = FRST_LEN + 22;
      low_cnt = 0; first_low = -1; rises = 0;
      prev_mute = mute;
      lrck = 1'b0; sel_changed = 1'b1; sel_in = 1'b0;
      for (int k = 1; k <= 110; k++) begin
         @(negedge clk);
         if (frontend_rst_n === 1'b0) begin
            low_cnt++;
            if (first_low < 0) first_low = k;
         end
         if ((mute === 1'b1) && (prev_mute === 1'b0)) rises++;
         prev_mute = mute;
         if (k == 1) begin
            checks += 2;
            if (mute !== 1'b1) begin errors++; $display("FAIL change mute_next: got %b expected 1", mute); end
            if (busy !== 1'b1) begin errors++; $display("FAIL change busy_next: got %b expected 1", busy); end
         end
         if (k == e2 + 63) begin
            checks++;
            if (mute !== 1'b1) begin errors++; $display("FAIL change mute_pre_timeout: got %b expected 1", mute); end
         end
         if (k == e2 + 64) begin
            checks++;
            if (mute !== 1'b0) begin errors++; $display("FAIL change mute_timeout: got %b expected 0", mute); end
         end
         if (k == 100) sel_changed = 1'b0;
      end
      checks += 5;
      if (low_cnt != LOW_LEN) begin errors++; $display("FAIL change rst_low_cycles: got %0d expected %0d", low_cnt, LOW_LEN); end
      if (first_low != EXP_FIRST) begin errors++; $display("FAIL change rst_first_cycle: got %0d expected %0d", first_low, EXP_FIRST); end
      if (rises != 1) begin errors++; $display("FAIL change sequences: got %0d expected 1", rises); end
      if (active_sel !== 1'b0) begin errors++; $display("FAIL change active_sel: got %b expected 0", active_sel); end
      if (busy !== 1'b0) begin errors++; $display("FAIL change busy_end: got %b expected 0", busy); end
   endtask

   // second change during SETTLE restarts at FRST without releasing mute
   task automatic test_resettle();
      int s;
      int end_k;
      int low_cnt;
      int early;
      s = FRST_LEN + 6;
      end_k = s + FRST_LEN + 22 + 64;
      low_cnt = 0; early = 0;
      sel_changed = 1'b1; sel_in = 1'b1;
      for (int k = 1; k <= end_k + 3; k++) begin
         @(negedge clk);
         if (frontend_rst_n === 1'b0) low_cnt++;
         if ((k < end_k) && (mute !== 1'b1)) early++;
         if (k == end_k) begin
            checks++;
            if (mute !== 1'b0) begin errors++; $display("FAIL resettle mute_end: got %b expected 0", mute); end
         end
         if (k == s + 3) begin
            checks++;
            if (active_sel !== 1'b1) begin errors++; $display("FAIL resettle first_switch: got %b expected 1", active_sel); end
         end
         if (k == 2) sel_changed = 1'b0;
         if (k == s + 4) begin sel_changed = 1'b1; sel_in = 1'b0; end
         if (k == s + 6) sel_changed = 1'b0;
      end
      checks += 4;
      if (early != 0) begin errors++; $display("FAIL resettle mute_dropped: got %0d expected 0", early); end
      if (low_cnt != 2 * LOW_LEN) begin errors++; $display("FAIL resettle rst_low_cycles: got %0d expected %0d", low_cnt, 2 * LOW_LEN); end
      if (active_sel !== 1'b0) begin errors++; $display("FAIL resettle active_sel: got %b expected 0", active_sel); end
      if (busy !== 1'b0) begin errors++; $display("FAIL resettle busy_end: got %b expected 0", busy); end
   endtask

   // asynchronous reset in UNMUTE, then a fresh power-up to completion
   task automatic test_reset_mid();
      int e;
      sel_in = 1'b1;
      for (int k = 1; k <= FRST_LEN + 32; k++) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL reset_mid busy_in_unmute: got %b expected 1", busy); end
      #2 reset = 1'b0;
      #1 check_reset_values("reset_mid_async");
      repeat (3) @(negedge clk);
      check_reset_values("reset_mid_held");
      reset = 1'b1;
      e = FRST_LEN + 17;
      for (int k = 1; k <= e + 64; k++) begin
         @(negedge clk);
         if (k == e + 63) begin
            checks++;
            if (mute !== 1'b1) begin errors++; $display("FAIL reset_mid mute_pre_timeout: got %b expected 1", mute); end
         end
      end
      checks += 3;
      if (mute !== 1'b0) begin errors++; $display("FAIL reset_mid mute_timeout: got %b expected 0", mute); end
      if (active_sel !== 1'b1) begin errors++; $display("FAIL reset_mid active_sel: got %b expected 1", active_sel); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy_end: got %b expected 0", busy); end
   endtask

   initial begin
      exp_frst_rst = FE_EN ? 1'b0 : 1'b1;
      test_reset();
      test_powerup();
      test_sel_change();
      test_resettle();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
